// File: rtl/game_referee_if.sv
// Ball-engine / referee link: ball position one way, match status the other.
interface game_referee_if;
    logic [11:0] Ball_X;
    logic [11:0] Ball_Y;
    logic [1:0]  game_state;
    logic        who_win;
    logic [3:0]  player_score;
    logic [3:0]  npc_score;
    logic        point_pulse;

    modport master (
        output Ball_X, Ball_Y,
        input  game_state, who_win, player_score, npc_score, point_pulse
    );

    modport slave (
        input  Ball_X, Ball_Y,
        output game_state, who_win, player_score, npc_score, point_pulse
    );
endinterface

// File: rtl/game_referee.sv
// Rally/score referee: qualifies ball landings, awards points by court side,
// and sequences start -> serve drop -> play -> match end.
module game_referee #(
    parameter int BALL_W      = 30,
    parameter int BALL_H      = 30,
    parameter int GROUND_Y    = 220,
    parameter int NET_POS_X   = 160,
    parameter int NET_W       = 6,
    parameter int LAND_CYCLES = 4,
    parameter int DROP_CYCLES = 100000000,
    parameter int WIN_SCORE   = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_btn,
    game_referee_if.slave bus
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_DROP  = 2'd1,
        S_PLAY  = 2'd2,
        S_END   = 2'd3
    } state_t;

    localparam int WIN_EFF = (WIN_SCORE < 1) ? 1 : ((WIN_SCORE > 15) ? 15 : WIN_SCORE);
    localparam int DW      = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
    localparam int LW      = (LAND_CYCLES > 1) ? $clog2(LAND_CYCLES) : 1;

    localparam logic [DW-1:0] DROP_LAST = DW'(DROP_CYCLES - 1);
    localparam logic [LW-1:0] LAND_LAST = LW'(LAND_CYCLES - 1);
    localparam logic [3:0]    WIN_VAL   = 4'(WIN_EFF);
    localparam logic [12:0]   BALL_H13  = 13'(BALL_H);
    localparam logic [12:0]   HALF_W13  = 13'(BALL_W / 2);
    localparam logic [12:0]   GROUND13  = 13'(GROUND_Y);
    localparam logic [12:0]   NET_C13   = 13'(NET_POS_X + NET_W / 2);

    state_t        state_q, state_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [LW-1:0] land_q, land_d;
    logic [3:0]    ps_q, ps_d;
    logic [3:0]    ns_q, ns_d;
    logic          ww_q, ww_d;
    logic          pulse_q, pulse_d;
    logic          landed;
    logic          left_side;

    // 13-bit sums so a ball near the 12-bit limit cannot wrap into a landing
    assign landed    = ({1'b0, bus.Ball_Y} + BALL_H13) >= GROUND13;
    assign left_side = ({1'b0, bus.Ball_X} + HALF_W13) < NET_C13;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_START;
            drop_q  <= '0;
            land_q  <= '0;
            ps_q    <= '0;
            ns_q    <= '0;
            ww_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            land_q  <= land_d;
            ps_q    <= ps_d;
            ns_q    <= ns_d;
            ww_q    <= ww_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        land_d  = land_q;
        ps_d    = ps_q;
        ns_d    = ns_q;
        ww_d    = ww_q;
        pulse_d = 1'b0;

        case (state_q)
            S_START, S_END: begin
                if (start_btn) begin
                    ps_d    = '0;
                    ns_d    = '0;
                    ww_d    = 1'b0;
                    drop_d  = '0;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                land_d = '0;
                if (drop_q == DROP_LAST) begin
                    drop_d  = '0;
                    state_d = S_PLAY;
                end else begin
                    drop_d = drop_q + DW'(1);
                end
            end
            S_PLAY: begin
                if (!landed) begin
                    land_d = '0;
                end else if (land_q == LAND_LAST) begin
                    land_d  = '0;
                    pulse_d = 1'b1;
                    ww_d    = !left_side;
                    if (left_side) begin
                        ps_d    = ps_q + 4'd1;
                        state_d = (ps_q + 4'd1 == WIN_VAL) ? S_END : S_DROP;
                    end else begin
                        ns_d    = ns_q + 4'd1;
                        state_d = (ns_q + 4'd1 == WIN_VAL) ? S_END : S_DROP;
                    end
                end else begin
                    land_d = land_q + LW'(1);
                end
            end
            default: state_d = S_START;
        endcase
    end

    assign bus.game_state   = state_q;
    assign bus.who_win      = ww_q;
    assign bus.player_score = ps_q;
    assign bus.npc_score    = ns_q;
    assign bus.point_pulse  = pulse_q;

endmodule

// File: tb/tb_game_referee.sv
// Directed bench for game_referee with short drop/land windows and a 3-point match.
module tb_game_referee;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_btn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    game_referee_if bus();

    game_referee #(
        .LAND_CYCLES(3),
        .DROP_CYCLES(10),
        .WIN_SCORE  (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_btn(start_btn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input int s);
        int budget = 0;
        while (int'(bus.game_state) != s && budget < 100) begin
            step(1);
            budget++;
        end
        check(tag, int'(bus.game_state), s);
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
    endtask

    // Hold a landed ball at x for three cycles; point registers on the third edge
    task automatic land_at(input int x, input int y);
        bus.Ball_X = 12'(x);
        bus.Ball_Y = 12'(y);
        step(2);
        check("no_early_pulse", int'(bus.point_pulse), 0);
        step(1);
        check("award_pulse", int'(bus.point_pulse), 1);
        bus.Ball_Y = 12'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, int'(bus.game_state), 0);
        check({tag, "_who"}, int'(bus.who_win), 0);
        check({tag, "_ps"}, int'(bus.player_score), 0);
        check({tag, "_ns"}, int'(bus.npc_score), 0);
        check({tag, "_pulse"}, int'(bus.point_pulse), 0);
    endtask

    initial begin
        bus.Ball_X = 12'd0;
        bus.Ball_Y = 12'd0;
        step(2);
        check_all_zero("reset");
        reset = 1'b0;
        step(2);
        check("idle_start", int'(bus.game_state), 0);

        // 1: serve drop lasts exactly 10 cycles
        pulse_start();
        check("enter_drop", int'(bus.game_state), 1);
        for (int i = 1; i < 10; i++) begin
            step(1);
            check("in_drop", int'(bus.game_state), 1);
        end
        step(1);
        check("enter_play", int'(bus.game_state), 2);
        check("play_ps", int'(bus.player_score), 0);
        check("play_ns", int'(bus.npc_score), 0);

        // 2: left-court landing scores for the player
        land_at(50, 190);
        check("t2_ps", int'(bus.player_score), 1);
        check("t2_who", int'(bus.who_win), 0);
        check("t2_state", int'(bus.game_state), 1);
        step(1);
        check("pulse_one_cycle", int'(bus.point_pulse), 0);
        wait_state("t3_wait_play", 2);

        // 3: two-cycle glitch must reset the landing count
        bus.Ball_X = 12'd250;
        bus.Ball_Y = 12'd190;
        step(2);
        bus.Ball_Y = 12'd100;
        step(1);
        check("glitch_pulse", int'(bus.point_pulse), 0);
        bus.Ball_Y = 12'd195;
        step(2);
        check("relanding_pulse", int'(bus.point_pulse), 0);
        check("relanding_ns", int'(bus.npc_score), 0);
        step(1);
        check("t3_pulse", int'(bus.point_pulse), 1);
        check("t3_ns", int'(bus.npc_score), 1);
        check("t3_who", int'(bus.who_win), 1);
        bus.Ball_Y = 12'd0;
        wait_state("t4a_wait_play", 2);

        // 4: net boundary, centre 162 is left, centre 163 is not
        land_at(147, 190);
        check("t4a_ps", int'(bus.player_score), 2);
        check("t4a_who", int'(bus.who_win), 0);
        wait_state("t4b_wait_play", 2);
        land_at(148, 190);
        check("t4b_ns", int'(bus.npc_score), 2);
        check("t4b_who", int'(bus.who_win), 1);
        check("t4b_ps", int'(bus.player_score), 2);
        wait_state("t5_wait_play", 2);

        // 5: third player point ends the match; button on the award cycle is dropped
        bus.Ball_X = 12'd50;
        bus.Ball_Y = 12'd190;
        step(2);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        check("t5_pulse", int'(bus.point_pulse), 1);
        check("t5_state", int'(bus.game_state), 3);
        check("t5_ps", int'(bus.player_score), 3);
        check("t5_who", int'(bus.who_win), 0);
        step(5);
        check("end_frozen_ps", int'(bus.player_score), 3);
        check("end_frozen_ns", int'(bus.npc_score), 2);
        check("end_no_pulse", int'(bus.point_pulse), 0);
        check("end_hold", int'(bus.game_state), 3);
        bus.Ball_Y = 12'd0;
        pulse_start();
        check("restart_state", int'(bus.game_state), 1);
        check("restart_ps", int'(bus.player_score), 0);
        check("restart_ns", int'(bus.npc_score), 0);
        check("restart_who", int'(bus.who_win), 0);

        // 6a: reset mid-drop clears immediately
        step(5);
        reset = 1'b1;
        #1;
        check_all_zero("rst_drop");
        step(2);
        reset = 1'b0;
        step(3);
        check("after_rst_idle", int'(bus.game_state), 0);

        // 6b: reset with two landed cycles counted, no point emerges
        pulse_start();
        wait_state("t6_wait_play", 2);
        bus.Ball_X = 12'd50;
        bus.Ball_Y = 12'd190;
        step(2);
        reset = 1'b1;
        #1;
        check_all_zero("rst_play");
        step(1);
        check("rst_play_no_pulse", int'(bus.point_pulse), 0);
        check("rst_play_no_score", int'(bus.player_score), 0);
        reset = 1'b0;
        step(4);
        check_all_zero("after_rst_play");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
